// File: rtl/or_unit_arbiter.sv
// or_unit_arbiter: one shared bitwise-OR datapath time-shared among
// four requesters by a round-robin arbiter, one result held at a time.
module or_unit_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [1:0]            rsp_id,
    output logic                  busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]       state;
    logic [1:0]       last_grant;
    logic [NREQ-1:0]  grant;
    logic [1:0]       grant_idx;
    logic [1:0]       cand;
    logic             found;
    logic             open;
    logic             accept;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = last_grant + 2'(k);
            if (!found && req_valid[cand]) begin
                found           = 1'b1;
                grant[cand]     = 1'b1;
                grant_idx       = cand;
            end
        end
    end

    // Window is open when nothing is held or the held result drains now;
    // held low throughout reset so no stray accept strobe escapes.
    always_comb begin
        open      = rst_n && ((state == ST_IDLE) || rsp_ready);
        req_ready = open ? grant : '0;
        accept    = |req_ready;
        sel_a     = req_a[int'(grant_idx)*WIDTH +: WIDTH];
        sel_b     = req_b[int'(grant_idx)*WIDTH +: WIDTH];
    end

    // State, result register and pointer; pointer moves only on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rsp_data   <= '0;
            rsp_id     <= '0;
            last_grant <= 2'd3;
        end else if (accept) begin
            state      <= ST_HOLD;
            rsp_data   <= sel_a | sel_b;
            rsp_id     <= grant_idx;
            last_grant <= grant_idx;
        end else if (state == ST_HOLD && rsp_ready) begin
            state      <= ST_IDLE;
        end
    end

    // A result is valid exactly while it is held.
    always_comb begin
        rsp_valid = (state == ST_HOLD);
        busy      = rsp_valid;
    end

endmodule

// File: tb/tb_or_unit_arbiter.sv
// Bench for or_unit_arbiter: directed vector table, hand sequences
// and randomized traffic against a behavioural model.
module tb_or_unit_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        busy;

    int passed = 0;
    int total  = 0;

    or_unit_arbiter #(.WIDTH(8), .NREQ(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_id(rsp_id),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [3:0]  v;
        logic [31:0] a;
        logic [31:0] b;
        logic        rr;
        logic [3:0]  e_ready;
        logic        e_valid;
        logic [7:0]  e_data;
        logic [1:0]  e_id;
    } row_t;

    // Behavioural model state
    bit       m_held;
    bit [7:0] m_data;
    int       m_id;
    int       m_ptr;

    function automatic row_t mk(logic rs, logic [3:0] v, logic [31:0] a,
                                logic [31:0] b, logic rr, logic [3:0] er,
                                logic ev, logic [7:0] ed, logic [1:0] ei);
        row_t r;
        r.rst_n = rs; r.v = v; r.a = a; r.b = b; r.rr = rr;
        r.e_ready = er; r.e_valid = ev; r.e_data = ed; r.e_id = ei;
        return r;
    endfunction

    function automatic logic [3:0] model_ready(logic rs, logic [3:0] v,
                                               logic rr);
        int i;
        if (!rs) return 4'b0000;
        if (m_held && !rr) return 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            i = (m_ptr + k) % 4;
            if (v[i]) return 4'(1 << i);
        end
        return 4'b0000;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        else
            passed++;
    endtask

    task automatic run(row_t r, bit use_model);
        logic [3:0] er;
        logic       ev;
        logic [7:0] ed;
        logic [1:0] ei;
        logic [3:0] mr;
        int         g;
        rst_n     = r.rst_n;
        req_valid = r.v;
        req_a     = r.a;
        req_b     = r.b;
        rsp_ready = r.rr;
        @(negedge clk);
        mr = model_ready(r.rst_n, r.v, r.rr);
        if (use_model) begin
            er = mr; ev = m_held; ed = m_data; ei = 2'(m_id);
        end else begin
            er = r.e_ready; ev = r.e_valid; ed = r.e_data; ei = r.e_id;
        end
        check("req_ready", 32'(req_ready), 32'(er));
        check("rsp_valid", 32'(rsp_valid), 32'(ev));
        check("busy",      32'(busy),      32'(ev));
        check("rsp_data",  32'(rsp_data),  32'(ed));
        check("rsp_id",    32'(rsp_id),    32'(ei));
        if (!r.rst_n) begin
            m_held = 0; m_data = 8'h00; m_id = 0; m_ptr = 3;
        end else if (mr != 4'b0000) begin
            g = 0;
            for (int i = 0; i < 4; i++) if (mr[i]) g = i;
            m_data = 8'(r.a >> (8*g)) | 8'(r.b >> (8*g));
            m_id   = g;
            m_ptr  = g;
            m_held = 1;
        end else if (m_held && r.rr) begin
            m_held = 0;
        end
        @(posedge clk);
        #1;
    endtask

    row_t tbl[$];
    localparam logic [31:0] A4 = 32'h08040201;
    localparam logic [31:0] B4 = 32'h80402010;

    initial begin
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        m_held = 0; m_data = 8'h00; m_id = 0; m_ptr = 3;

        // reset state, then single request
        tbl.push_back(mk(0, 4'b1111, 0, 0, 1, 4'b0000, 0, 8'h00, 0));
        tbl.push_back(mk(1, 4'b0001, 32'h0F, 32'hF0, 1, 4'b0001, 0, 8'h00, 0));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 4'b0000, 1, 8'hFF, 0));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 8'hFF, 0));
        // reset then all four back-to-back
        tbl.push_back(mk(0, 4'b1111, A4, B4, 1, 4'b0000, 0, 8'hFF, 0));
        tbl.push_back(mk(1, 4'b1111, A4, B4, 1, 4'b0001, 0, 8'h00, 0));
        tbl.push_back(mk(1, 4'b1111, A4, B4, 1, 4'b0010, 1, 8'h11, 0));
        tbl.push_back(mk(1, 4'b1111, A4, B4, 1, 4'b0100, 1, 8'h22, 1));
        tbl.push_back(mk(1, 4'b1111, A4, B4, 1, 4'b1000, 1, 8'h44, 2));
        tbl.push_back(mk(1, 4'b1111, A4, B4, 1, 4'b0001, 1, 8'h88, 3));
        tbl.push_back(mk(1, 4'b0000, A4, B4, 1, 4'b0000, 1, 8'h11, 0));
        tbl.push_back(mk(1, 4'b0000, A4, B4, 1, 4'b0000, 0, 8'h11, 0));
        // zero operands on requester 1
        tbl.push_back(mk(1, 4'b0010, 0, 0, 0, 4'b0010, 0, 8'h11, 0));
        tbl.push_back(mk(1, 4'b0010, 0, 0, 0, 4'b0000, 1, 8'h00, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 4'b0000, 1, 8'h00, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 8'h00, 1));
        foreach (tbl[i]) run(tbl[i], 0);

        // backpressure on requester 2, then requester 3 same cycle
        run(mk(1, 4'b0100, 32'h33810000, 32'h0C180000, 0,
               4'b0100, 0, 8'h00, 1), 0);
        for (int i = 0; i < 5; i++)
            run(mk(1, 4'b1000, 32'h33810000, 32'h0C180000, 0,
                   4'b0000, 1, 8'h99, 2), 0);
        run(mk(1, 4'b1000, 32'h33810000, 32'h0C180000, 1,
               4'b1000, 1, 8'h99, 2), 0);
        // pointer wrap after requester 3
        run(mk(1, 4'b1001, 32'h3381005A, 32'h0C180000, 1,
               4'b0001, 1, 8'h3F, 3), 0);
        run(mk(1, 4'b1001, 32'h3381005A, 32'h0C180000, 1,
               4'b1000, 1, 8'h5A, 0), 0);
        // reset while holding requester 1's result
        run(mk(1, 4'b0010, 32'h0000225A, 32'h00004400, 1,
               4'b0010, 1, 8'h3F, 3), 0);
        run(mk(0, 4'b1111, 32'h0000225A, 32'h00004400, 1,
               4'b0000, 1, 8'h66, 1), 0);
        run(mk(1, 4'b1111, 32'h0000225A, 32'h00004400, 1,
               4'b0001, 0, 8'h00, 0), 0);
        run(mk(1, 4'b0000, 32'h0000225A, 32'h00004400, 1,
               4'b0000, 1, 8'h5A, 0), 0);
        run(mk(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 8'h5A, 0), 0);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            row_t r;
            r = mk(($urandom_range(0, 39) != 0), 4'($urandom),
                   32'($urandom), 32'($urandom),
                   ($urandom_range(0, 2) != 0), 4'b0, 0, 8'h00, 0);
            run(r, 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/or_unit_arbiter.md
OR_UNIT_ARBITER -- requirements
Module: or_unit_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits.
REQ-002 Parameter: NREQ, fixed 4, number of requesters; other values are out of scope.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  4  per-requester request valid; bit i belongs to requester i.
REQ-006 req_ready  output  4  per-requester accept strobe; at most one bit high per cycle.
REQ-007 req_a  input  4*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 req_b  input  4*WIDTH  operand B; same packing as req_a.
REQ-009 rsp_valid  output  1  result valid.
REQ-010 rsp_ready  input  1  consumer accepts the result.
REQ-011 rsp_data  output  WIDTH  registered result, req_a[i] | req_b[i] of the granted requester.
REQ-012 rsp_id  output  2  index of the requester that owns rsp_data.
REQ-013 busy  output  1  high while a result is held (state HOLD).

Function
REQ-014 The block shall time-share one bitwise-OR datapath (WIDTH bits, a | b) among 4 requesters, with one transaction outstanding at a time.
REQ-015 State machine: IDLE (no result held) and HOLD (result held, rsp_valid=1).
- IDLE -> HOLD on any request accept.
- HOLD -> IDLE on rsp_valid&&rsp_ready with no simultaneous accept.
- HOLD -> HOLD on rsp handshake with a simultaneous accept.
REQ-016 Accept window: open = (state==IDLE) || (state==HOLD && rsp_ready).
- req_ready is combinational from state, rsp_ready, req_valid and the RR pointer.
- req_ready[i] = open && grant[i].
REQ-017 Grant: round-robin over req_valid.
- Search starts at (last_grant+1) mod 4 and wraps 3->0.
- The first asserted bit wins.
- grant is one-hot or zero.
REQ-018 Transfer: a request transfer occurs when req_valid[i]&&req_ready[i].
- On that edge: rsp_data <= req_a[i]|req_b[i]; rsp_id <= i; last_grant <= i.
REQ-019 Latency: an accept at edge t shall present rsp_valid=1 with the result after edge t; one cycle from accept to visible result.
REQ-020 Throughput: with rsp_ready held high and requests pending, one transaction shall complete every cycle (back-to-back).
REQ-021 Hold stability: while rsp_valid=1 and rsp_ready=0, rsp_data, rsp_id and last_grant shall not change; req_ready shall be all zero.
REQ-022 last_grant shall update only on an accept; idle cycles and non-accepted req_valid shall not move the pointer.
REQ-023 Fairness: a requester holding req_valid high shall be granted within 4 accepts.
REQ-024 A requester may drop req_valid before it is accepted; no transfer occurs and no state changes for it.
REQ-025 req_valid all zero with the window open: no accept; HOLD exits to IDLE if the result is consumed.
REQ-026 busy shall equal rsp_valid.

Reset
REQ-027 When rst_n=0 at a rising edge, the block shall set:
- state = IDLE
- rsp_valid = 0, rsp_data = 0, rsp_id = 0
- busy = 0
- last_grant = 3, so that requester 0 has first priority after reset.
REQ-028 While rst_n=0, req_ready shall be all zero.
REQ-029 Reset asserted in HOLD shall discard the held result; no handshake shall complete in that cycle.
REQ-030 First accept is possible on the first edge with rst_n=1.

Verification
REQ-031 Reset then single request:
- Stimulus: req_valid=0001, a0=0x0F, b0=0xF0, rsp_ready=1.
- Response: req_ready=0001 for 1 cycle; next cycle rsp_valid=1, rsp_data=0xFF, rsp_id=0.
REQ-032 All four requesting continuously, rsp_ready=1:
- Response: rsp_id sequence 0,1,2,3,0 on consecutive cycles; rsp_data[k] = a|b of that requester.
REQ-033 Backpressure:
- Stimulus: rsp_ready=0 for 5 cycles after an accept of requester 2 (a=0x81, b=0x18).
- Response: rsp_data=0x99 and rsp_id=2 stable; req_ready=0000 throughout.
- Then rsp_ready=1 with req_valid=1000: requester 3 accepted in the same cycle.
REQ-034 Pointer wrap:
- Stimulus: last accept was requester 3; then req_valid=1001.
- Response: grant=0001.
- Then req_valid=1001 again: grant=1000.
REQ-035 Reset mid-operation:
- Stimulus: rst_n=0 while in HOLD with rsp_id=1.
- Response: next cycle rsp_valid=0, busy=0, rsp_data=0.
- Then req_valid=1111: grant=0001.
REQ-036 Zero operands:
- Stimulus: a=0x00, b=0x00 on requester 1.
- Response: rsp_valid=1, rsp_data=0x00, rsp_id=1; a valid zero result is distinct from idle.
